// File: rtl/pipe_buffer.sv
// Two-entry registered pipeline buffer (main + skid) with flush and a saturating
// count of cycles in which downstream held off a valid output.
module pipe_buffer #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] inAdder,
   input  logic [DATA_W-1:0] inRD1,
   input  logic [DATA_W-1:0] inRD2,
   input  logic [DATA_W-1:0] inSignExt,
   input  logic [REG_W-1:0]  inInsA,
   input  logic [REG_W-1:0]  inInsB,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] outAdder,
   output logic [DATA_W-1:0] outRD1,
   output logic [DATA_W-1:0] outRD2,
   output logic [DATA_W-1:0] outSignExt,
   output logic [REG_W-1:0]  outInsA,
   output logic [REG_W-1:0]  outInsB,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PW = 4 * DATA_W + 2 * REG_W;

   logic [PW-1:0]    r_main_data;
   logic [PW-1:0]    r_skid_data;
   logic             r_main_v;
   logic             r_skid_v;
   logic [CNT_W-1:0] r_stall_cnt;

   logic [PW-1:0]    w_in_data;
   logic             w_in_xfer;

   assign w_in_data = {inAdder, inRD1, inRD2, inSignExt, inInsA, inInsB};
   // Readiness depends only on the skid flop, so upstream never sees a path from out_ready.
   assign w_in_xfer = in_valid & ~r_skid_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_data <= '0;
         r_skid_data <= '0;
         r_main_v    <= 1'b0;
         r_skid_v    <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         if (r_main_v && !out_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);

         if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
         end else if (!r_main_v) begin
            if (w_in_xfer) begin
               r_main_v    <= 1'b1;
               r_main_data <= w_in_data;
            end
         end else if (out_ready) begin
            if (r_skid_v) begin
               r_main_data <= r_skid_data;
               r_skid_v    <= w_in_xfer;
               if (w_in_xfer)
                  r_skid_data <= w_in_data;
            end else if (w_in_xfer) begin
               r_main_data <= w_in_data;
            end else begin
               r_main_v <= 1'b0;
            end
         end else if (w_in_xfer) begin
            r_skid_v    <= 1'b1;
            r_skid_data <= w_in_data;
         end
      end
   end

   assign in_ready  = ~r_skid_v;
   assign out_valid = r_main_v;
   assign occupancy = {r_main_v & r_skid_v, r_main_v ^ r_skid_v};
   assign stall_cnt = r_stall_cnt;
   assign {outAdder, outRD1, outRD2, outSignExt, outInsA, outInsB} = r_main_data;

endmodule

// File: doc/pipe_buffer.md
PIPE_BUFFER -- requirements
Module: pipe_buffer

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, width of adder/rd1/rd2/signext fields; REG_W, default 5, width of insA/insB fields; CNT_W, default 16, width of stall counter.
REQ-002 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  buffer can accept this cycle
- inAdder, inRD1, inRD2, inSignExt  in  DATA_W each  payload
- inInsA, inInsB  in  REG_W each  payload
- out_valid  out  1  outAdder..outInsB hold a valid entry
- out_ready  in  1  downstream consumes this cycle
- outAdder, outRD1, outRD2, outSignExt  out  DATA_W each  payload
- outInsA, outInsB  out  REG_W each  payload
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Function
REQ-003 Storage SHALL be two entries: a main register driving out* directly and a skid register; all outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-004 An input transfer SHALL occur when in_valid && in_ready at a rising clk edge; an output transfer SHALL occur when out_valid && out_ready.
REQ-005 Entries SHALL leave in arrival order; no entry is duplicated or dropped except by flush.
REQ-006 Latency SHALL be 1 cycle: an entry accepted into an empty buffer appears on out* with out_valid=1 at the next edge.
REQ-007 Main empty, input transfer: entry goes to main.
REQ-008 Main full, output transfer, skid full: skid moves to main; a simultaneous input entry goes to skid.
REQ-009 Main full, output transfer, skid empty: input entry (if any) goes to main, else main becomes empty.
REQ-010 Main full, no output transfer, input transfer: entry goes to skid.
REQ-011 in_ready SHALL be 1 exactly when the skid is empty, decided from the registered state only.
REQ-012 occupancy SHALL equal the number of valid entries after each edge; out_valid SHALL equal (occupancy != 0).
REQ-013 When main empties, out* payload SHALL hold its last value; only out_valid drops.
REQ-014 flush=1 SHALL clear both valid bits at the edge, overriding any simultaneous input/output transfer; the next cycle has out_valid=0, occupancy=0, in_ready=1; payload registers are not cleared.
REQ-015 stall_cnt SHALL increment by 1 on each edge where out_valid && !out_ready, SHALL saturate at 2^CNT_W-1, and SHALL NOT be cleared by flush.
REQ-016 Sustained in_valid=1, out_ready=1 SHALL give one transfer per cycle with occupancy steady at 1.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for clk, force out_valid=0, occupancy=0, stall_cnt=0, in_ready=1, and all out* payload and skid payload to 0.
REQ-018 The first edge after rst_n rises SHALL already accept input.

Verification
REQ-019 Reset mid-operation: occupancy=2, drop rst_n between edges -> out_valid=0, in_ready=1, outAdder=0, stall_cnt=0 before the next edge.
REQ-020 Single entry: inAdder=0x00000010, inInsA=3, out_ready=1 -> next cycle out_valid=1, outAdder=0x10, outInsA=3, occupancy=1; following cycle, no input -> out_valid=0, outAdder still 0x10.
REQ-021 Backpressure: out_ready=0, send A=0x1 then B=0x2 -> occupancy=2, in_ready=0, input C=0x3 refused; out_ready=1 -> outputs A, B, C in order; stall_cnt counts every stalled cycle.
REQ-022 Streaming: 100 consecutive entries 0..99, in_valid=out_ready=1 -> outputs 0..99 in consecutive cycles, occupancy=1 throughout, stall_cnt=0.
REQ-023 Flush priority: occupancy=2, flush=1 with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, and the offered entry is lost.
REQ-024 Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15, no wrap.
